// File: rtl/data_memo_master.sv
// rtl/data_memo_master.sv - burst initiator for the single-port data memory
//
// Accepts read/write burst requests from the core, sequences them into
// one memory access per beat, returns read words one per cycle and takes
// write words through a per-beat handshake.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_write, req_addr, req_len   burst direction, first word, beats minus one
//   wr_valid/wr_ready, wr_data     write-word handshake (WRITE bursts only)
//   rd_valid, rd_data              registered read word, one pulse per beat
//   done, err                      end-of-burst pulse; err marks a rejected request
//   mem_*                          data memory address/enable/data connections

module data_memo_master #(
  parameter int DEPTH = 32,
  parameter int LEN_W = 3,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [BUS_W-1:0] req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [BUS_W-1:0] wr_data,
  output logic             rd_valid,
  output logic [BUS_W-1:0] rd_data,
  output logic             done,
  output logic             err,
  output logic [BUS_W-1:0] mem_address,
  output logic [BUS_W-1:0] mem_input_data,
  output logic             mem_enable_read,
  output logic             mem_enable_write,
  input  logic [BUS_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [BUS_W:0] DEPTH_X = (BUS_W + 1)'(DEPTH);

  state_t             state_q, state_d;
  logic [BUS_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   beats_left_q, beats_left_d;
  logic               is_err_q, is_err_d;
  logic               rd_valid_q, rd_valid_d;
  logic [BUS_W-1:0]   rd_data_q, rd_data_d;

  // Last word of the burst, one bit wider than the bus so the sum cannot wrap.
  logic [BUS_W:0]     last_addr;
  logic               out_of_range;

  assign last_addr    = {1'b0, req_addr} + {{(BUS_W + 1 - LEN_W){1'b0}}, req_len};
  assign out_of_range = ({1'b0, req_addr} >= DEPTH_X) || (last_addr >= DEPTH_X);

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      is_err_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      is_err_q     <= is_err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cur_addr_d       = cur_addr_q;
    beats_left_d     = beats_left_q;
    is_err_d         = is_err_q;
    rd_valid_d       = 1'b0;
    rd_data_d        = rd_data_q;
    req_ready        = 1'b0;
    wr_ready         = 1'b0;
    done             = 1'b0;
    err              = 1'b0;
    mem_address      = '0;
    mem_input_data   = '0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Held low while reset is high so the requester never sees a
        // handshake that the reset is about to discard.
        req_ready = !reset;
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          if (out_of_range) begin
            is_err_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = req_write ? S_WRITE : S_READ;
          end
        end
      end

      S_READ: begin
        mem_enable_read = 1'b1;
        mem_address     = cur_addr_q;
        rd_valid_d      = 1'b1;
        rd_data_d       = mem_read_data;
        cur_addr_d      = cur_addr_q + BUS_W'(1);
        beats_left_d    = beats_left_q - LEN_W'(1);
        if (beats_left_q == '0) state_d = S_DONE;
      end

      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_enable_write = 1'b1;
          mem_address      = cur_addr_q;
          mem_input_data   = wr_data;
          cur_addr_d       = cur_addr_q + BUS_W'(1);
          beats_left_d     = beats_left_q - LEN_W'(1);
          if (beats_left_q == '0) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done     = 1'b1;
        err      = is_err_q;
        is_err_d = 1'b0;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_memo_master.sv
// tb/tb_data_memo_master.sv - self-checking bench for data_memo_master

module tb_data_memo_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_input_data;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic [31:0] mem_read_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] tb_mem  [32];
  logic [31:0] ref_mem [32];
  logic [31:0] wdata   [8];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int          obs_en_r, obs_en_w, obs_done_cnt, obs_done_cyc, obs_addr_bad, obs_ready_busy;
  logic        obs_err, obs_ready0;
  logic [31:0] obs_rd [$];

  data_memo_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  assign mem_read_data = (mem_address < 32) ? tb_mem[mem_address[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (pl_en) tb_mem[pl_addr] <= pl_data;
    else if (mem_enable_write && mem_address < 32) tb_mem[mem_address[4:0]] <= mem_input_data;
  end

  // Always-on checks: enable exclusivity, rd_valid only after a read access cycle.
  logic prev_rd_en = 1'b0;
  always @(negedge clk) begin
    #3;
    n_cmp++;
    if (mem_enable_read && mem_enable_write) begin
      n_fail++;
      $display("FAIL enable_exclusive t=%0t: rd_en=%b wr_en=%b, required not both", $time, mem_enable_read, mem_enable_write);
    end
    n_cmp++;
    if (rd_valid && !prev_rd_en) begin
      n_fail++;
      $display("FAIL rd_valid_origin t=%0t: rd_valid=1 without read access in previous cycle", $time);
    end
    prev_rd_en = mem_enable_read;
  end

  // Drives one request and records what the DUT does until done (or budget).
  // Cycle 0 is the request cycle; cycle k is k cycles after the accepting edge.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [2:0] len,
                         input int gap_at, input int gap_len,
                         input logic hold_next, input logic [31:0] next_addr, input logic [2:0] next_len);
    int n = int'(len) + 1;
    int sent = 0;
    int gap_cnt = 0;
    int cyc = 0;
    obs_en_r = 0; obs_en_w = 0; obs_done_cnt = 0; obs_done_cyc = -1;
    obs_addr_bad = 0; obs_ready_busy = 0; obs_err = 1'b0;
    obs_rd.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
    #1 obs_ready0 = req_ready;
    while (obs_done_cnt == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hold_next) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = next_addr; req_len = next_len;
      end else begin
        req_valid = 1'b0;
      end
      wr_valid = 1'b0;
      wr_data  = $urandom;
      if (wr && sent < n) begin
        if (sent == gap_at && gap_cnt < gap_len) gap_cnt++;
        else begin
          wr_valid = 1'b1;
          wr_data  = wdata[sent];
        end
      end
      #1;
      if (req_ready) obs_ready_busy++;
      if (mem_enable_read) begin
        if (mem_address !== addr + 32'(obs_en_r)) obs_addr_bad++;
        obs_en_r++;
      end
      if (mem_enable_write) begin
        if (mem_address !== addr + 32'(obs_en_w) || mem_input_data !== wr_data) obs_addr_bad++;
        obs_en_w++;
      end
      if (wr_valid && wr_ready) sent++;
      if (rd_valid) obs_rd.push_back(rd_data);
      if (done) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
        obs_err = err;
      end
    end
    wr_valid = 1'b0;
    if (!hold_next) req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 5'(i);
      pl_data = (i == 5) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, wr_ready, done, err, rd_valid, mem_enable_read, mem_enable_write} !== 7'b0 ||
        rd_data !== 32'h0 || mem_address !== 32'h0 || mem_input_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b wrdy=%b done=%b err=%b rdv=%b rdd=%h addr=%h, required all 0",
               req_ready, wr_ready, done, err, rd_valid, rd_data, mem_address);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_single_read;
    run_req(1'b0, 32'd5, 3'd0, 0, 0, 1'b0, 32'd0, 3'd0);
    n_cmp++;
    if (obs_ready0 !== 1'b1 || obs_done_cyc != 2 || obs_err !== 1'b0 || obs_en_r != 1) begin
      n_fail++;
      $display("FAIL single_read_timing: ready=%b done_cyc=%0d err=%b en_r=%0d, required 1/2/0/1",
               obs_ready0, obs_done_cyc, obs_err, obs_en_r);
    end
    n_cmp++;
    if (obs_rd.size() != 1 || obs_rd[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_read_data: got %0d words first=%h, required 1 word DEADBEEF",
               obs_rd.size(), (obs_rd.size() > 0) ? obs_rd[0] : 32'hx);
    end
  endtask

  task automatic test_burst_write_read;
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
    run_req(1'b1, 32'd28, 3'd3, 2, 2, 1'b0, 32'd0, 3'd0);
    for (int i = 0; i < 4; i++) ref_mem[28 + i] = wdata[i];
    n_cmp++;
    if (obs_en_w != 4 || obs_en_r != 0 || obs_addr_bad != 0 || obs_done_cyc != 7 || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_write: en_w=%0d en_r=%0d bad=%0d done_cyc=%0d err=%b, required 4/0/0/7/0",
               obs_en_w, obs_en_r, obs_addr_bad, obs_done_cyc, obs_err);
    end
    run_req(1'b0, 32'd28, 3'd3, 0, 0, 1'b0, 32'd0, 3'd0);
    n_cmp++;
    if (obs_rd.size() != 4 || obs_done_cyc != 5) begin
      n_fail++;
      $display("FAIL burst_readback_len: words=%0d done_cyc=%0d, required 4/5", obs_rd.size(), obs_done_cyc);
    end
    for (int i = 0; i < obs_rd.size() && i < 4; i++) begin
      n_cmp++;
      if (obs_rd[i] !== 32'(8'h11 * (i + 1))) begin
        n_fail++;
        $display("FAIL burst_readback_word%0d: got %h, required %h", i, obs_rd[i], 32'(8'h11 * (i + 1)));
      end
    end
  endtask

  task automatic test_bounds;
    logic [31:0] a_tab [2];
    logic [2:0]  l_tab [2];
    a_tab[0] = 32'd30;        l_tab[0] = 3'd2;
    a_tab[1] = 32'hFFFFFFFF;  l_tab[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      run_req(k[0], a_tab[k], l_tab[k], 0, 0, 1'b0, 32'd0, 3'd0);
      n_cmp++;
      if (obs_done_cyc != 1 || obs_err !== 1'b1 || obs_en_r + obs_en_w != 0 || obs_rd.size() != 0) begin
        n_fail++;
        $display("FAIL bounds_reject%0d: done_cyc=%0d err=%b enables=%0d rdv=%0d, required 1/1/0/0",
                 k, obs_done_cyc, obs_err, obs_en_r + obs_en_w, obs_rd.size());
      end
    end
    run_req(1'b0, 32'd24, 3'd7, 0, 0, 1'b0, 32'd0, 3'd0);
    n_cmp++;
    if (obs_done_cyc != 9 || obs_err !== 1'b0 || obs_en_r != 8 || obs_addr_bad != 0 || obs_rd.size() != 8) begin
      n_fail++;
      $display("FAIL bounds_edge_accept: done_cyc=%0d err=%b en_r=%0d bad=%0d words=%0d, required 9/0/8/0/8",
               obs_done_cyc, obs_err, obs_en_r, obs_addr_bad, obs_rd.size());
    end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (obs_rd[i] !== ref_mem[24 + i]) begin
          n_fail++;
          $display("FAIL bounds_edge_word%0d: got %h, required %h", i, obs_rd[i], ref_mem[24 + i]);
        end
      end
    end
  endtask

  task automatic test_busy;
    run_req(1'b0, 32'd0, 3'd7, 0, 0, 1'b1, 32'd10, 3'd2);
    n_cmp++;
    if (obs_ready_busy != 0 || obs_done_cyc != 9) begin
      n_fail++;
      $display("FAIL busy_ready_low: ready_cycles=%0d done_cyc=%0d, required 0/9", obs_ready_busy, obs_done_cyc);
    end
    run_req(1'b0, 32'd10, 3'd2, 0, 0, 1'b0, 32'd0, 3'd0);
    n_cmp++;
    if (obs_ready0 !== 1'b1 || obs_done_cyc != 4 || obs_rd.size() != 3 ||
        obs_rd[0] !== ref_mem[10] || obs_rd[1] !== ref_mem[11] || obs_rd[2] !== ref_mem[12]) begin
      n_fail++;
      $display("FAIL busy_second_req: ready=%b done_cyc=%0d words=%0d, required 1/4/3 with memory data",
               obs_ready0, obs_done_cyc, obs_rd.size());
    end
  endtask

  task automatic test_reset_mid;
    int done_seen = 0;
    for (int i = 0; i < 6; i++) wdata[i] = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd0; req_len = 3'd5;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      wr_valid = 1'b1; wr_data = wdata[c - 1];
      #1 if (done) done_seen++;
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, wr_ready, done, err, rd_valid, mem_enable_read, mem_enable_write} !== 7'b0 ||
        rd_data !== 32'h0 || mem_address !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdy=%b wrdy=%b done=%b wen=%b rdd=%h addr=%h, required all 0",
               req_ready, wr_ready, done, mem_enable_write, rd_data, mem_address);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 if (done) done_seen++;
    n_cmp++;
    if (done_seen != 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_recover: done_pulses=%0d ready=%b, required 0/1", done_seen, req_ready);
    end
    ref_mem[0] = wdata[0];
    ref_mem[1] = wdata[1];
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (tb_mem[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL reset_mid_mem%0d: got %h, required %h", i, tb_mem[i], ref_mem[i]);
      end
    end
    run_req(1'b0, 32'd0, 3'd5, 0, 0, 1'b0, 32'd0, 3'd0);
    n_cmp++;
    if (obs_done_cyc != 7 || obs_rd.size() != 6 || obs_rd[0] !== wdata[0] || obs_rd[1] !== wdata[1]) begin
      n_fail++;
      $display("FAIL reset_mid_next_req: done_cyc=%0d words=%0d, required 7/6 with written data",
               obs_done_cyc, obs_rd.size());
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 24; it++) begin
      logic        wr = 1'($urandom_range(0, 1));
      logic [31:0] addr = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(28, 40)) : 32'($urandom_range(0, 31));
      logic [2:0]  len = 3'($urandom_range(0, 7));
      int          gap_at = $urandom_range(0, 8);
      int          gap_len = $urandom_range(0, 3);
      int          n = int'(len) + 1;
      longint      last = longint'(addr) + longint'(len);
      logic        rej = (last >= 32);
      int          exp_done;
      int          mem_diff = 0;
      for (int i = 0; i < 8; i++) wdata[i] = $urandom;
      run_req(wr, addr, len, gap_at, gap_len, 1'b0, 32'd0, 3'd0);
      if (rej) exp_done = 1;
      else if (wr) exp_done = n + ((gap_at < n) ? gap_len : 0) + 1;
      else exp_done = n + 1;
      n_cmp++;
      if (obs_ready0 !== 1'b1 || obs_done_cyc != exp_done || obs_err !== rej || obs_addr_bad != 0 ||
          obs_en_r != ((!rej && !wr) ? n : 0) || obs_en_w != ((!rej && wr) ? n : 0)) begin
        n_fail++;
        $display("FAIL random%0d_ctrl: wr=%b addr=%0d len=%0d done_cyc=%0d(req %0d) err=%b(req %b) en_r=%0d en_w=%0d bad=%0d",
                 it, wr, addr, len, obs_done_cyc, exp_done, obs_err, rej, obs_en_r, obs_en_w, obs_addr_bad);
      end
      if (!rej && wr) for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[i];
      n_cmp++;
      if (obs_rd.size() != ((!rej && !wr) ? n : 0)) begin
        n_fail++;
        $display("FAIL random%0d_rd_count: got %0d, required %0d", it, obs_rd.size(), (!rej && !wr) ? n : 0);
      end
      else begin
        for (int i = 0; i < obs_rd.size(); i++) if (obs_rd[i] !== ref_mem[int'(addr) + i]) mem_diff++;
      end
      for (int i = 0; i < 32; i++) if (tb_mem[i] !== ref_mem[i]) mem_diff++;
      n_cmp++;
      if (mem_diff != 0) begin
        n_fail++;
        $display("FAIL random%0d_data: %0d words differ from reference", it, mem_diff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write_read();
    test_bounds();
    test_busy();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
